// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider and its EX-stage interface.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'd0,
        DIV_BY_ZERO = 2'd1,
        DIV_ON      = 2'd2,
        DIV_END     = 2'd3
    } div_state_t;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam int REG_BUS_W        = 32;
    localparam int DOUBLE_REG_BUS_W = 2 * REG_BUS_W;

    localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between EX and the divider.
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int WIDTH = REG_BUS_W
) ();

    logic               i_start;
    logic               i_signed_div;
    logic [WIDTH-1:0]   i_opdata1;
    logic [WIDTH-1:0]   i_opdata2;
    logic               i_annul;
    logic [2*WIDTH-1:0] o_result;
    logic               o_ready;

    modport master (
        output i_start, i_signed_div, i_opdata1, i_opdata2, i_annul,
        input  o_result, o_ready
    );

    modport slave (
        input  i_start, i_signed_div, i_opdata1, i_opdata2, i_annul,
        output o_result, o_ready
    );

endinterface

// File: rtl/div_unit_step.sv
// One restoring-division step: shift the working register left and trial-subtract the divisor.
module div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] i_work,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [2*WIDTH:0] o_work
);

    logic [WIDTH+1:0] w_upper;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;

    // Shifted partial remainder can reach W+2 bits before the compare; after a
    // successful subtract it is below the divisor, so W+1 bits hold the difference.
    assign w_upper = i_work[2*WIDTH:WIDTH-1];
    assign w_ge    = (w_upper >= {2'b00, i_divisor});
    assign w_diff  = w_upper[WIDTH:0] - {1'b0, i_divisor};

    assign o_work = w_ge ? {w_diff, i_work[WIDTH-2:0], 1'b1}
                         : {w_upper[WIDTH:0], i_work[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU; returns {remainder, quotient}.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = REG_BUS_W
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    div_unit_if.slave bus
);

    localparam int                CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t         r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [2*WIDTH-1:0] r_result, w_result_nxt;
    logic               r_ready, w_ready_nxt;

    logic [2*WIDTH:0]   r_work, w_work_nxt, w_work_step;
    logic [WIDTH-1:0]   r_divisor, w_divisor_nxt;
    logic               r_neg_q, r_neg_r, w_neg_q_nxt, w_neg_r_nxt;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic as_signed);
        return (as_signed && v[WIDTH-1]) ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [2*WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] q_mag,
                                                    input logic [WIDTH-1:0] r_mag,
                                                    input logic neg_q,
                                                    input logic neg_r);
        logic signed [WIDTH-1:0] q;
        logic signed [WIDTH-1:0] r;
        q = neg_q ? -$signed(q_mag) : $signed(q_mag);
        r = neg_r ? -$signed(r_mag) : $signed(r_mag);
        return {r, q};
    endfunction

    div_unit_step #(.WIDTH(WIDTH)) u_step (
        .i_work    (r_work),
        .i_divisor (r_divisor),
        .o_work    (w_work_step)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_result_nxt  = r_result;
        w_ready_nxt   = r_ready;
        w_work_nxt    = r_work;
        w_divisor_nxt = r_divisor;
        w_neg_q_nxt   = r_neg_q;
        w_neg_r_nxt   = r_neg_r;
        case (r_state)
            DIV_FREE: begin
                w_cnt_nxt    = '0;
                w_result_nxt = '0;
                w_ready_nxt  = DIV_RESULT_NOT_READY;
                if (bus.i_start == DIV_START && !bus.i_annul) begin
                    if (bus.i_opdata2 == '0) begin
                        w_state_nxt = DIV_BY_ZERO;
                    end else begin
                        w_state_nxt   = DIV_ON;
                        w_work_nxt    = {{(WIDTH+1){1'b0}},
                                         magnitude(bus.i_opdata1, bus.i_signed_div)};
                        w_divisor_nxt = magnitude(bus.i_opdata2, bus.i_signed_div);
                        w_neg_q_nxt   = bus.i_signed_div &
                                        (bus.i_opdata1[WIDTH-1] ^ bus.i_opdata2[WIDTH-1]);
                        w_neg_r_nxt   = bus.i_signed_div & bus.i_opdata1[WIDTH-1];
                    end
                end
            end
            DIV_BY_ZERO: begin
                w_state_nxt  = DIV_END;
                w_result_nxt = '0;
                w_ready_nxt  = DIV_RESULT_READY;
            end
            DIV_ON: begin
                // Annul (or EX abandoning the request) wins over the final step.
                if (bus.i_annul || bus.i_start == DIV_STOP) begin
                    w_state_nxt  = DIV_FREE;
                    w_cnt_nxt    = '0;
                    w_result_nxt = '0;
                    w_ready_nxt  = DIV_RESULT_NOT_READY;
                end else begin
                    w_work_nxt = w_work_step;
                    w_cnt_nxt  = r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        w_state_nxt  = DIV_END;
                        w_result_nxt = sign_fix(w_work_step[WIDTH-1:0],
                                                w_work_step[2*WIDTH-1:WIDTH],
                                                r_neg_q, r_neg_r);
                        w_ready_nxt  = DIV_RESULT_READY;
                    end
                end
            end
            DIV_END: begin
                if (bus.i_start == DIV_STOP) begin
                    w_state_nxt  = DIV_FREE;
                    w_cnt_nxt    = '0;
                    w_result_nxt = '0;
                    w_ready_nxt  = DIV_RESULT_NOT_READY;
                end
            end
            default: begin
                w_state_nxt  = DIV_FREE;
                w_cnt_nxt    = '0;
                w_result_nxt = '0;
                w_ready_nxt  = DIV_RESULT_NOT_READY;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= DIV_FREE;
            r_cnt    <= '0;
            r_result <= '0;
            r_ready  <= DIV_RESULT_NOT_READY;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    // Operand datapath is always written before it is read, so it carries no reset.
    always_ff @(posedge i_clk) begin
        r_work    <= w_work_nxt;
        r_divisor <= w_divisor_nxt;
        r_neg_q   <= w_neg_q_nxt;
        r_neg_r   <= w_neg_r_nxt;
    end

    assign bus.o_result = r_result;
    assign bus.o_ready  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit with an arithmetic reference model and per-cycle compare.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int W   = REG_BUS_W;
    localparam int LAT = W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [DOUBLE_REG_BUS_W-1:0] spec_div(input logic [W-1:0] a,
                                                             input logic [W-1:0] b,
                                                             input logic s);
        longint q;
        longint r;
        if (b == '0) return '0;
        if (s) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'({32'h0, a}) / longint'({32'h0, b});
            r = longint'({32'h0, a}) % longint'({32'h0, b});
        end
        return {r[W-1:0], q[W-1:0]};
    endfunction

    // Reference: idle / busy (countdown to ready) / holding result.
    int                          m_phase;
    int                          m_left;
    bit                          m_dz;
    logic                        m_ready;
    logic [DOUBLE_REG_BUS_W-1:0] m_res;
    logic [DOUBLE_REG_BUS_W-1:0] m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_dz    <= 1'b0;
            m_ready <= 1'b0;
            m_res   <= '0;
            m_pend  <= '0;
        end else begin
            case (m_phase)
                0: if (bus.i_start && !bus.i_annul) begin
                    m_phase <= 1;
                    m_dz    <= (bus.i_opdata2 == '0);
                    m_left  <= (bus.i_opdata2 == '0) ? 1 : LAT;
                    m_pend  <= spec_div(bus.i_opdata1, bus.i_opdata2, bus.i_signed_div);
                end
                1: if (!m_dz && (bus.i_annul || !bus.i_start)) begin
                    m_phase <= 0;
                end else if (m_left == 1) begin
                    m_phase <= 2;
                    m_ready <= 1'b1;
                    m_res   <= m_pend;
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (!bus.i_start) begin
                    m_phase <= 0;
                    m_ready <= 1'b0;
                    m_res   <= '0;
                end
            endcase
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input int lat, input logic [63:0] exp);
        int  n;
        bit  got;
        check({nm, " model"}, spec_div(a, b, s), exp);
        bus.i_start      = 1'b1;
        bus.i_signed_div = s;
        bus.i_opdata1    = a;
        bus.i_opdata2    = b;
        bus.i_annul      = 1'b0;
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            tick();
            n++;
            got = bus.o_ready;
        end
        check({nm, " latency"}, 64'(n - 1), 64'(lat));
        check({nm, " result"}, bus.o_result, exp);
        tick();
        check({nm, " hold"}, {bus.o_ready, bus.o_result}, {1'b1, exp});
        bus.i_start = 1'b0;
        tick();
        check({nm, " release"}, {bus.o_ready, bus.o_result}, {1'b0, ZERO_WORD, ZERO_WORD});
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_start      = 1'b0;
        bus.i_signed_div = 1'b0;
        bus.i_opdata1    = '0;
        bus.i_opdata2    = '0;
        bus.i_annul      = 1'b0;
        fork
            forever begin
                @(negedge clk);
                check("cycle", {bus.o_ready, bus.o_result}, {m_ready, m_res});
            end
        join_none

        #1 rst_n = 1'b0;
        #1;
        check("reset outputs", {bus.o_ready, bus.o_result}, 65'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle after reset", {63'h0, bus.o_ready}, 64'h0);

        do_op("u100/7",    32'd100,        32'd7,          1'b0, LAT, 64'h00000002_0000000E);
        do_op("s-7/2",     32'hFFFFFFF9,   32'h00000002,   1'b1, LAT, 64'hFFFFFFFF_FFFFFFFD);
        do_op("u-7/2",     32'hFFFFFFF9,   32'h00000002,   1'b0, LAT, 64'h00000001_7FFFFFFC);
        do_op("s-min/-1",  32'h80000000,   32'hFFFFFFFF,   1'b1, LAT, 64'h00000000_80000000);
        do_op("u123/0",    32'd123,        32'd0,          1'b0, 1,   64'h0);
        do_op("s123/0",    32'd123,        32'd0,          1'b1, 1,   64'h0);
        do_op("u0/5",      32'd0,          32'd5,          1'b0, LAT, 64'h0);
        do_op("u5/9",      32'd5,          32'd9,          1'b0, LAT, 64'h00000005_00000000);
        do_op("s-100/-7",  32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, LAT, 64'hFFFFFFFE_0000000E);
        do_op("umax/1",    32'hFFFFFFFF,   32'd1,          1'b0, LAT, 64'h00000000_FFFFFFFF);

        // Annul on the tenth step edge, then hold request with annul for a few cycles.
        bus.i_start = 1'b1; bus.i_signed_div = 1'b0;
        bus.i_opdata1 = 32'd1000; bus.i_opdata2 = 32'd7; bus.i_annul = 1'b0;
        tick();
        repeat (9) tick();
        bus.i_annul = 1'b1;
        repeat (4) tick();
        check("annul ready", {63'h0, bus.o_ready}, 64'h0);
        bus.i_annul = 1'b0;
        bus.i_start = 1'b0;
        tick();
        do_op("u9/3",      32'd9,          32'd3,          1'b0, LAT, 64'h00000000_00000003);

        // Request dropped mid-division behaves like annul.
        bus.i_start = 1'b1; bus.i_opdata1 = 32'd50; bus.i_opdata2 = 32'd5;
        repeat (6) tick();
        bus.i_start = 1'b0;
        repeat (LAT + 4) tick();
        check("drop ready", {63'h0, bus.o_ready}, 64'h0);

        // Async reset while the result is being held, between clock edges.
        bus.i_start = 1'b1; bus.i_opdata1 = 32'd77; bus.i_opdata2 = 32'd4;
        repeat (LAT + 2) tick();
        check("pre-reset ready", {63'h0, bus.o_ready}, 64'h1);
        #2;
        rst_n = 1'b0;
        bus.i_start = 1'b0;
        #1;
        check("async reset end", {bus.o_ready, bus.o_result}, 65'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Async reset in the middle of a division.
        bus.i_start = 1'b1;
        repeat (8) tick();
        #2;
        rst_n = 1'b0;
        bus.i_start = 1'b0;
        #1;
        check("async reset on", {bus.o_ready, bus.o_result}, 65'h0);
        tick();
        rst_n = 1'b1;
        repeat (LAT + 4) tick();
        check("quiet after reset", {63'h0, bus.o_ready}, 64'h0);
        do_op("u15/4",     32'd15,         32'd4,          1'b0, LAT, 64'h00000003_00000003);

        // Back-to-back: do_op drops request for exactly one cycle before the next.
        do_op("u1000/33",  32'd1000,       32'd33,         1'b0, LAT, 64'h0000000A_0000001E);
        do_op("s77/-5",    32'd77,         32'hFFFFFFFB,   1'b1, LAT, 64'h00000002_FFFFFFF1);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
